// File: rtl/hazard_stall_controller.sv
// rtl/hazard_stall_controller.sv - pipeline stall/flush sequencer for load-use, branch and mult/div hazards
// Outputs are combinational; only the mult/div FSM, its timeout counter and the stall counter are registered.
module hazard_stall_controller #(
   parameter int MD_TIMEOUT = 64,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [4:0]       ID_rs,
   input  logic [4:0]       ID_rt,
   input  logic             ID_uses_rt,
   input  logic             ID_branch,
   input  logic             ID_branch_taken,
   input  logic             ID_jump,
   input  logic             EX_MemRead,
   input  logic             EX_RegWrite,
   input  logic [4:0]       EX_write_register,
   input  logic             MEM_MemRead,
   input  logic [4:0]       MEM_write_register,
   input  logic             EX_md_op,
   input  logic             md_done,
   output logic             PC_write,
   output logic             IF_ID_write,
   output logic             IF_ID_flush,
   output logic             ID_EX_write,
   output logic             ID_EX_flush,
   output logic             EX_MEM_flush,
   output logic             md_start,
   output logic             md_error,
   output logic [CNT_W-1:0] stall_count
);

   localparam logic [1:0] S_IDLE       = 2'd0;
   localparam logic [1:0] S_MD_BUSY    = 2'd1;
   localparam logic [1:0] S_MD_RELEASE = 2'd2;

   localparam int TW = (MD_TIMEOUT > 1) ? $clog2(MD_TIMEOUT) : 1;
   localparam logic [TW-1:0] TO_LAST = TW'(MD_TIMEOUT - 1);

   logic [1:0]       state_q, state_d;
   logic [TW-1:0]    to_cnt_q, to_cnt_d;
   logic             md_error_q, md_error_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   logic ex_hit_rs, ex_hit_rt, mem_hit_rs, mem_hit_rt;
   logic load_use, br_hazard, freeze;

   // Register 0 is hardwired, so a zero destination never creates a dependency.
   assign ex_hit_rs  = (EX_write_register != 5'd0) && (EX_write_register == ID_rs);
   assign ex_hit_rt  = (EX_write_register != 5'd0) && (EX_write_register == ID_rt);
   assign mem_hit_rs = (MEM_write_register != 5'd0) && (MEM_write_register == ID_rs);
   assign mem_hit_rt = (MEM_write_register != 5'd0) && (MEM_write_register == ID_rt);

   assign load_use  = EX_MemRead && (ex_hit_rs || (ID_uses_rt && ex_hit_rt));
   assign br_hazard = ID_branch && ((EX_RegWrite && (ex_hit_rs || ex_hit_rt)) ||
                                    (MEM_MemRead && (mem_hit_rs || mem_hit_rt)));
   assign freeze    = ((state_q == S_IDLE) && EX_md_op) || (state_q == S_MD_BUSY);

   always_comb begin
      PC_write     = 1'b1;
      IF_ID_write  = 1'b1;
      ID_EX_write  = 1'b1;
      IF_ID_flush  = 1'b0;
      ID_EX_flush  = 1'b0;
      EX_MEM_flush = 1'b0;
      md_start     = 1'b0;
      if (!rst_n) begin
         PC_write    = 1'b0;
         IF_ID_write = 1'b0;
         ID_EX_write = 1'b0;
         IF_ID_flush = 1'b1;
         ID_EX_flush = 1'b1;
      end else if (freeze) begin
         PC_write     = 1'b0;
         IF_ID_write  = 1'b0;
         ID_EX_write  = 1'b0;
         EX_MEM_flush = 1'b1;
         md_start     = (state_q == S_IDLE);
      end else if (load_use || br_hazard) begin
         // A taken branch held here is deliberately not flushed; it resolves again once released.
         PC_write    = 1'b0;
         IF_ID_write = 1'b0;
         ID_EX_flush = 1'b1;
      end else if (ID_branch_taken || ID_jump) begin
         IF_ID_flush = 1'b1;
      end
   end

   always_comb begin
      state_d    = state_q;
      to_cnt_d   = to_cnt_q;
      md_error_d = md_error_q;
      case (state_q)
         S_IDLE: begin
            if (EX_md_op) begin
               state_d  = S_MD_BUSY;
               to_cnt_d = '0;
            end
         end
         S_MD_BUSY: begin
            if (md_done) begin
               state_d = S_MD_RELEASE;
            end else if (to_cnt_q == TO_LAST) begin
               state_d    = S_MD_RELEASE;
               md_error_d = 1'b1;
            end else begin
               to_cnt_d = to_cnt_q + 1'b1;
            end
         end
         S_MD_RELEASE: state_d = S_IDLE;
         default:      state_d = S_IDLE;
      endcase
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (!PC_write && (stall_cnt_q != {CNT_W{1'b1}})) begin
         stall_cnt_d = stall_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         to_cnt_q    <= '0;
         md_error_q  <= 1'b0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         to_cnt_q    <= to_cnt_d;
         md_error_q  <= md_error_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign md_error    = md_error_q;
   assign stall_count = stall_cnt_q;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// tb/tb_hazard_stall_controller.sv - directed self-checking bench for hazard_stall_controller
module tb_hazard_stall_controller;

   localparam int CNT_W = 4;

   // Output vector order: PC_write, IF_ID_write, ID_EX_write, IF_ID_flush, ID_EX_flush, EX_MEM_flush, md_start
   localparam logic [6:0] O_RESET  = 7'b0001100;
   localparam logic [6:0] O_START  = 7'b0000011;
   localparam logic [6:0] O_FREEZE = 7'b0000010;
   localparam logic [6:0] O_STALL  = 7'b0010100;
   localparam logic [6:0] O_FLUSH  = 7'b1111000;
   localparam logic [6:0] O_NORM   = 7'b1110000;

   logic clk = 1'b0;
   logic rst_n;
   logic [4:0] ID_rs, ID_rt, EX_write_register, MEM_write_register;
   logic ID_uses_rt, ID_branch, ID_branch_taken, ID_jump;
   logic EX_MemRead, EX_RegWrite, MEM_MemRead, EX_md_op, md_done;
   logic PC_write, IF_ID_write, IF_ID_flush, ID_EX_write, ID_EX_flush, EX_MEM_flush;
   logic md_start, md_error;
   logic [CNT_W-1:0] stall_count;
   logic [6:0] outs;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   assign outs = {PC_write, IF_ID_write, ID_EX_write, IF_ID_flush, ID_EX_flush, EX_MEM_flush, md_start};

   hazard_stall_controller #(.MD_TIMEOUT(8), .CNT_W(CNT_W)) dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .ID_rs              (ID_rs),
      .ID_rt              (ID_rt),
      .ID_uses_rt         (ID_uses_rt),
      .ID_branch          (ID_branch),
      .ID_branch_taken    (ID_branch_taken),
      .ID_jump            (ID_jump),
      .EX_MemRead         (EX_MemRead),
      .EX_RegWrite        (EX_RegWrite),
      .EX_write_register  (EX_write_register),
      .MEM_MemRead        (MEM_MemRead),
      .MEM_write_register (MEM_write_register),
      .EX_md_op           (EX_md_op),
      .md_done            (md_done),
      .PC_write           (PC_write),
      .IF_ID_write        (IF_ID_write),
      .IF_ID_flush        (IF_ID_flush),
      .ID_EX_write        (ID_EX_write),
      .ID_EX_flush        (ID_EX_flush),
      .EX_MEM_flush       (EX_MEM_flush),
      .md_start           (md_start),
      .md_error           (md_error),
      .stall_count        (stall_count)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic clear_inputs();
      ID_rs = 5'd0; ID_rt = 5'd0; ID_uses_rt = 1'b0;
      ID_branch = 1'b0; ID_branch_taken = 1'b0; ID_jump = 1'b0;
      EX_MemRead = 1'b0; EX_RegWrite = 1'b0; EX_write_register = 5'd0;
      MEM_MemRead = 1'b0; MEM_write_register = 5'd0;
      EX_md_op = 1'b0; md_done = 1'b0;
   endtask

   task automatic next_cycle();
      @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0;
      clear_inputs();
      #3;
      check("reset_outs", 32'(outs), 32'(O_RESET));
      check("reset_cnt", 32'(stall_count), 32'd0);
      check("reset_err", 32'(md_error), 32'd0);

      next_cycle(); rst_n = 1'b1; #1;
      check("idle_outs", 32'(outs), 32'(O_NORM));

      // load-use on rs
      next_cycle(); EX_MemRead = 1'b1; EX_write_register = 5'd2; ID_rs = 5'd2; #1;
      check("lu_outs", 32'(outs), 32'(O_STALL));
      next_cycle(); clear_inputs(); #1;
      check("lu_release", 32'(outs), 32'(O_NORM));
      check("lu_cnt", 32'(stall_count), 32'd1);

      // register 0 and rt-not-used cases
      next_cycle(); EX_MemRead = 1'b1; EX_write_register = 5'd0; ID_rs = 5'd0; #1;
      check("reg0_outs", 32'(outs), 32'(O_NORM));
      next_cycle(); EX_write_register = 5'd5; ID_rt = 5'd5; ID_rs = 5'd1; ID_uses_rt = 1'b0; #1;
      check("no_rt_outs", 32'(outs), 32'(O_NORM));
      next_cycle(); ID_uses_rt = 1'b1; #1;
      check("rt_lu_outs", 32'(outs), 32'(O_STALL));
      next_cycle(); clear_inputs(); #1;
      check("rt_lu_cnt", 32'(stall_count), 32'd2);

      // branch hazard masks the taken-branch flush
      next_cycle();
      ID_branch = 1'b1; ID_branch_taken = 1'b1; EX_RegWrite = 1'b1;
      EX_write_register = 5'd7; ID_rs = 5'd7; #1;
      check("br_stall_outs", 32'(outs), 32'(O_STALL));
      next_cycle(); EX_write_register = 5'd3; #1;
      check("br_flush_outs", 32'(outs), 32'(O_FLUSH));
      check("br_cnt", 32'(stall_count), 32'd3);
      next_cycle(); clear_inputs();
      ID_branch = 1'b1; ID_rs = 5'd4; ID_rt = 5'd9; MEM_MemRead = 1'b1; MEM_write_register = 5'd9; #1;
      check("br_mem_outs", 32'(outs), 32'(O_STALL));
      next_cycle(); clear_inputs(); ID_jump = 1'b1; #1;
      check("jump_outs", 32'(outs), 32'(O_FLUSH));
      check("br_mem_cnt", 32'(stall_count), 32'd4);

      next_cycle(); clear_inputs(); rst_n = 1'b0; #1;
      check("rst2_cnt", 32'(stall_count), 32'd0);
      next_cycle(); rst_n = 1'b1;

      // mult/div with md_done in the fourth busy cycle
      next_cycle(); EX_md_op = 1'b1; #1;
      check("md_start_outs", 32'(outs), 32'(O_START));
      for (int i = 0; i < 4; i++) begin
         next_cycle(); md_done = (i == 3); #1;
         check("md_busy_outs", 32'(outs), 32'(O_FREEZE));
      end
      next_cycle(); md_done = 1'b0; #1;
      check("md_release_outs", 32'(outs), 32'(O_NORM));
      check("md_cnt", 32'(stall_count), 32'd5);
      // back-to-back op restarts from IDLE
      next_cycle(); #1;
      check("md_b2b_outs", 32'(outs), 32'(O_START));
      next_cycle(); md_done = 1'b1; #1;
      check("md_b2b_busy", 32'(outs), 32'(O_FREEZE));
      next_cycle(); md_done = 1'b0; EX_md_op = 1'b0; #1;
      check("md_b2b_rel", 32'(outs), 32'(O_NORM));
      check("md_b2b_cnt", 32'(stall_count), 32'd7);
      check("md_no_err", 32'(md_error), 32'd0);

      // timeout: 8 busy cycles without md_done; stall count saturates at 15
      next_cycle(); EX_md_op = 1'b1; md_done = 1'b0; #1;
      check("to_start", 32'(outs), 32'(O_START));
      for (int i = 0; i < 8; i++) begin
         next_cycle(); EX_md_op = 1'b0; #1;
         check("to_busy_outs", 32'(outs), 32'(O_FREEZE));
      end
      check("to_err_pre", 32'(md_error), 32'd0);
      next_cycle(); #1;
      check("to_release", 32'(outs), 32'(O_NORM));
      check("to_err", 32'(md_error), 32'd1);
      check("sat_cnt", 32'(stall_count), 32'd15);
      next_cycle(); EX_MemRead = 1'b1; EX_write_register = 5'd6; ID_rs = 5'd6; #1;
      check("sat_stall", 32'(outs), 32'(O_STALL));
      next_cycle(); clear_inputs(); #1;
      check("sat_hold", 32'(stall_count), 32'd15);
      check("err_sticky", 32'(md_error), 32'd1);

      // reset while busy
      next_cycle(); EX_md_op = 1'b1; #1;
      check("rb_start", 32'(outs), 32'(O_START));
      next_cycle(); #1;
      check("rb_busy", 32'(outs), 32'(O_FREEZE));
      rst_n = 1'b0; #1;
      check("rb_outs", 32'(outs), 32'(O_RESET));
      check("rb_err", 32'(md_error), 32'd0);
      check("rb_cnt", 32'(stall_count), 32'd0);
      next_cycle(); rst_n = 1'b1; EX_md_op = 1'b0; #1;
      check("rb_idle", 32'(outs), 32'(O_NORM));
      next_cycle(); #1;
      check("rb_idle_cnt", 32'(stall_count), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/hazard_stall_controller.md
Name: hazard_stall_controller

Overview:
Central stall/flush sequencer for the 5-stage MIPS pipeline. It sits beside the forwarding unit and covers the hazards that forwarding cannot resolve: load-use, branch operands in ID, and the multi-cycle mult/div unit in EX. It drives PC and pipeline-register write enables and flushes, issues the mult/div start pulse, and keeps a stall performance counter.

Parameters:
MD_TIMEOUT, 64, max cycles in MD_BUSY without md_done before a forced release
CNT_W, 16, width of the saturating stall counter

Ports:
clk  input  1  pipeline clock, rising edge
rst_n  input  1  asynchronous active-low reset
ID_rs  input  5  rs of instruction in ID
ID_rt  input  5  rt of instruction in ID
ID_uses_rt  input  1  ID instruction reads rt as a source
ID_branch  input  1  ID instruction is a branch comparing rs/rt in ID
ID_branch_taken  input  1  branch resolved taken in ID
ID_jump  input  1  jump in ID
EX_MemRead  input  1  EX instruction is a load
EX_RegWrite  input  1  EX instruction writes the register file
EX_write_register  input  5  EX destination
MEM_MemRead  input  1  MEM instruction is a load
MEM_write_register  input  5  MEM destination
EX_md_op  input  1  mult/div instruction in EX
md_done  input  1  mult/div unit result valid
PC_write  output  1  PC enable
IF_ID_write  output  1  IF/ID enable
IF_ID_flush  output  1  zero IF/ID on next edge
ID_EX_write  output  1  ID/EX enable
ID_EX_flush  output  1  bubble into ID/EX
EX_MEM_flush  output  1  bubble into EX/MEM
md_start  output  1  one-cycle start pulse to mult/div unit
md_error  output  1  sticky timeout flag
stall_count  output  CNT_W  saturating count of cycles with PC_write=0

Behaviour:
- Async reset (rst_n=0): state=IDLE, timeout counter=0, stall_count=0, md_error=0. While rst_n=0: PC_write=0, IF_ID_write=0, ID_EX_write=0, IF_ID_flush=1, ID_EX_flush=1, EX_MEM_flush=0, md_start=0.
- Stall/flush outputs are combinational from state and inputs (same-cycle effect). State, timeout counter, stall_count and md_error are registered.
- Register 0 never causes a hazard.
- load_use = EX_MemRead & EX_write_register!=0 & (EX_write_register==ID_rs | (ID_uses_rt & EX_write_register==ID_rt)).
- br_hazard = ID_branch & ((EX_RegWrite & dest_EX matches rs/rt) | (MEM_MemRead & dest_MEM matches rs/rt)).
- States:
  - IDLE
  - MD_BUSY
  - MD_RELEASE
- Transitions:
  - IDLE & EX_md_op -> MD_BUSY. md_start=1 in this cycle only. Timeout counter cleared.
  - MD_BUSY & md_done -> MD_RELEASE.
  - MD_BUSY & counter==MD_TIMEOUT-1 & !md_done -> MD_RELEASE. md_error is set (sticky until reset).
  - MD_RELEASE -> IDLE unconditionally. EX_md_op is ignored in this cycle, so the finishing op cannot restart.
  - md_done outside MD_BUSY is ignored.
- Output priority, highest first:
  1. Freeze: IDLE&EX_md_op, or MD_BUSY. PC_write=IF_ID_write=ID_EX_write=0, EX_MEM_flush=1, ID_EX_flush=0, IF_ID_flush=0.
  2. load_use or br_hazard: PC_write=IF_ID_write=0, ID_EX_write=1, ID_EX_flush=1, IF_ID_flush=0.
  3. ID_branch_taken | ID_jump (no stall): IF_ID_flush=1, all writes 1.
  4. Default: all writes 1, all flushes 0.
- A pending taken branch under a stall does not flush; it is re-evaluated when released.
- MD_RELEASE applies priorities 2–4 normally.
- stall_count increments on every edge where PC_write=0 and rst_n=1. It holds at 2^CNT_W-1 and never wraps.
- Back-to-back mult/div: a second op reaching EX the cycle after MD_RELEASE starts from IDLE normally.
- Reset mid-MD_BUSY aborts immediately to IDLE without md_error.

Test Plan:
- Load-use: EX_MemRead=1, EX_write_register=2, ID_rs=2 -> PC_write=0, IF_ID_write=0, ID_EX_flush=1 for 1 cycle; stall_count 0->1.
- Reg-0 and no-rt cases: EX_write_register=0, ID_rs=0 -> no stall. EX_write_register=5, ID_rt=5, ID_uses_rt=0 -> no stall.
- Branch hazard vs flush: ID_branch=1, ID_branch_taken=1, EX_RegWrite=1, EX_write_register=ID_rs=7 -> stall, IF_ID_flush=0. Next cycle with no match -> IF_ID_flush=1.
- Mult/div: EX_md_op=1 -> md_start pulse for 1 cycle, freeze with EX_MEM_flush=1. md_done 4 cycles later -> MD_RELEASE, writes resume, then IDLE; stall_count=5; no second md_start while EX_md_op still 1 in release.
- Timeout: MD_TIMEOUT=8, md_done never asserted -> forced release after 8 cycles, md_error=1 and held until rst_n=0.
- Reset mid-busy: rst_n low in MD_BUSY -> IDLE, md_error=0, stall_count=0, reset output values as above.
